trees_spawner: RTL
==================

// Module: trees_spawner
// PURPOSE
//  Producer side of the 8-slot tree object bus: owns the position and alive state of 8 tree slots.
//  Spawns trees at a random X on a frame-based interval, moves live trees down each frame and retires them off-screen.
//  Drives the packed coordinate bus ([i][0]=X, [i][1]=Y) into the per-tree drawers and the depth-sorting trees mux.
//  Clears a slot when the collision logic reports a hit on that slot.
// PARAMETERS
//  SPAWN_FRAMES  30      frames between spawn attempts (>=2)
//  SPAWN_Y       11'd0   Y loaded into a newly spawned tree
//  BOTTOM_Y      11'd480 retire a tree when its new Y >= BOTTOM_Y
//  X_MIN         11'd32  X offset added to the 9-bit random value
//  PARK_Y        11'd0   Y (and X=0) driven for inactive slots
//  LFSR_SEED     16'hACE1 LFSR reset value (must be nonzero)
// PORTS
//  clk               in   1          system clock
//  resetN            in   1          async active-low reset
//  startOfFrame      in   1          1-cycle pulse per video frame
//  spawnEnable       in   1          1 = spawn attempts allowed
//  speed             in   4          Y pixels added per frame to every live tree
//  collisionRequest  in   8          bit i = tree i was hit; retire slot i
//  treesCoordinates  out  [7:0][1:0][10:0]  per-slot {Y,X}, registered
//  treesActive       out  8          bit i = slot i live, registered
//  treeCount         out  4          number of live slots (0..8), registered
//  spawnMissed       out  1          1-cycle pulse: spawn due but all 8 slots live
// BEHAVIOUR
//  Reset: all outputs 0; coordinates = {PARK_Y,0}; FSM=IDLE; frame counter=0; lfsr=LFSR_SEED.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clk, including in IDLE.
//  FSM: IDLE -> MOVE on startOfFrame; MOVE -> SPAWN; SPAWN -> IDLE (always 1 cycle each).
//   - startOfFrame while not IDLE is ignored.
//  MOVE: for every live slot, newY = Y + speed (11-bit, zero-extended).
//   - If newY >= BOTTOM_Y: the slot goes inactive and its coords are parked.
//   - Otherwise Y <= newY.
//   - All 8 slots update in the same cycle. Frame counter increments.
//   - The counter wraps to 0 when it reaches SPAWN_FRAMES-1; that wrap marks "spawn due".
//  SPAWN: if spawn due and spawnEnable:
//   - Pick the lowest-index inactive slot and load X = X_MIN + lfsr[8:0], Y = SPAWN_Y, active=1.
//   - If no slot is free, pulse spawnMissed; no slot changes.
//   - Spawn due with spawnEnable=0: attempt dropped silently, counter still wrapped.
//  Collision: in any state, collisionRequest[i]=1 on a live slot clears it next edge and parks its coords.
//   - Collision on an inactive slot: no effect.
//   - Collision wins over MOVE for the same slot.
//   - Collision on the slot being spawned in the same SPAWN cycle is ignored; the new tree survives.
//  treeCount = popcount of next treesActive, registered with it (same-cycle consistent).
//  Latency: coords from a frame pulse at edge t are valid after edge t+2 (MOVE); a spawned tree appears after edge t+3.
//  Outputs change only in MOVE/SPAWN or on a collision; stable for the rest of the frame.
//  Reset mid-frame returns to IDLE, parks all slots and clears the counter; no partial update survives.
// CONFIGURATION
//  TREES_RAMP_EN defined:
//   - Each successful spawn decrements the effective interval by 1 frame, floor SPAWN_FRAMES/2.
//   - The interval restores to SPAWN_FRAMES on reset.
//  TREES_RAMP_EN undefined: interval fixed at SPAWN_FRAMES; no ramp register synthesized.
// TESTING
//  Reset, spawnEnable=1, speed=0, SPAWN_FRAMES=2, 4 frames -> slots 0,1 active.
//   - X in [32,543], Y=0, treeCount=2, spawnMissed never.
//  One live tree at Y=470, speed=15, one frame -> slot retired.
//   - treesActive=0, coords {0,0}, treeCount=0.
//  All 8 slots live, spawn due -> spawnMissed one 1-cycle pulse; treesActive stays 8'hFF.
//  collisionRequest=8'h04 while slot 2 live, then on an idle slot -> slot 2 cleared next edge.
//   - Idle-slot hit: no change. Same-cycle hit during SPAWN of slot 2: tree kept.
//  Reset asserted during MOVE with 5 live trees -> all outputs 0 immediately.
//   - First spawn after release comes SPAWN_FRAMES frames later into slot 0.
//  TREES_RAMP_EN, SPAWN_FRAMES=8 -> spawn gaps 8,7,6,5,4,4 frames.

Source files
------------

// File: rtl/trees_spawner.sv
// trees_spawner: owns 8 tree slots (X/Y, alive), spawns at random X,
// moves trees down per frame, retires off-screen or on collision hit.
// In : clk, resetN, startOfFrame, spawnEnable, speed[3:0], collisionRequest[7:0]
// Out: treesCoordinates[7:0][1:0][10:0] ([i][0]=X,[i][1]=Y), treesActive[7:0],
//      treeCount[3:0], spawnMissed (1-cycle pulse)
// Option: define TREES_RAMP_EN to shorten the spawn interval per spawn.
module trees_spawner #(
  parameter int          SPAWN_FRAMES = 30,
  parameter logic [10:0] SPAWN_Y      = 11'd0,
  parameter logic [10:0] BOTTOM_Y     = 11'd480,
  parameter logic [10:0] X_MIN        = 11'd32,
  parameter logic [10:0] PARK_Y       = 11'd0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  spawnEnable,
  input  logic [3:0]            speed,
  input  logic [7:0]            collisionRequest,
  output logic [7:0][1:0][10:0] treesCoordinates,
  output logic [7:0]            treesActive,
  output logic [3:0]            treeCount,
  output logic                  spawnMissed
);
  localparam int CW = $clog2(SPAWN_FRAMES + 1);
  localparam logic [CW-1:0] FRAMES = CW'(SPAWN_FRAMES);
  localparam logic [21:0] PARKED = {PARK_Y, 11'd0};

  typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;
  state_t r_state, w_state_nxt;

  logic [15:0]           r_lfsr;
  logic                  w_fb;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_interval;
  logic                  r_due, w_due_nxt;
  logic [7:0]            r_active, w_act_nxt;
  logic [7:0][1:0][10:0] r_coords, w_crd_nxt;
  logic [3:0]            r_count, w_count_nxt;
  logic                  r_missed, w_missed_nxt;
  logic                  w_spawn_ok, w_free;
  logic [2:0]            w_slot;
  logic [7:0][10:0]      w_newy;

  assign treesCoordinates = r_coords;
  assign treesActive      = r_active;
  assign treeCount        = r_count;
  assign spawnMissed      = r_missed;

  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  for (genvar g = 0; g < 8; g++) begin : g_newy
    assign w_newy[g] = r_coords[g][1] + {7'd0, speed};
  end

`ifdef TREES_RAMP_EN
  localparam logic [CW-1:0] FLOOR = CW'(SPAWN_FRAMES / 2);
  logic [CW-1:0] r_interval;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_interval <= FRAMES;
    else if (w_spawn_ok && r_interval > FLOOR)
      r_interval <= r_interval - 1'b1;
  end
  assign w_interval = r_interval;
`else
  assign w_interval = FRAMES;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (startOfFrame) w_state_nxt = MOVE;
      MOVE:    w_state_nxt = SPAWN;
      SPAWN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_act_nxt    = r_active;
    w_crd_nxt    = r_coords;
    w_cnt_nxt    = r_cnt;
    w_due_nxt    = r_due;
    w_missed_nxt = 1'b0;
    w_free       = 1'b0;
    w_slot       = 3'd0;
    // descending scan leaves the lowest free index
    for (int i = 7; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free = 1'b1;
        w_slot = 3'(i);
      end
    end
    w_spawn_ok = (r_state == SPAWN) && r_due
                 && spawnEnable && w_free;
    if (r_state == MOVE) begin
      for (int i = 0; i < 8; i++) begin
        if (r_active[i]) begin
          if (w_newy[i] >= BOTTOM_Y) begin
            w_act_nxt[i] = 1'b0;
            w_crd_nxt[i] = PARKED;
          end else begin
            w_crd_nxt[i][1] = w_newy[i];
          end
        end
      end
      if (r_cnt == w_interval - 1'b1) begin
        w_cnt_nxt = '0;
        w_due_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_due_nxt = 1'b0;
      end
    end
    if (r_state == SPAWN) begin
      w_due_nxt    = 1'b0;
      w_missed_nxt = r_due && spawnEnable && !w_free;
    end
    // hits override movement; the spawn slot is free so a hit there
    // is a no-op and the load below keeps the new tree
    for (int i = 0; i < 8; i++) begin
      if (r_active[i] && collisionRequest[i]) begin
        w_act_nxt[i] = 1'b0;
        w_crd_nxt[i] = PARKED;
      end
    end
    if (w_spawn_ok) begin
      w_act_nxt[w_slot]    = 1'b1;
      w_crd_nxt[w_slot][0] = X_MIN + {2'b00, r_lfsr[8:0]};
      w_crd_nxt[w_slot][1] = SPAWN_Y;
    end
    w_count_nxt = '0;
    for (int i = 0; i < 8; i++)
      w_count_nxt = w_count_nxt + {3'd0, w_act_nxt[i]};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lfsr   <= LFSR_SEED;
      r_cnt    <= '0;
      r_due    <= 1'b0;
      r_active <= '0;
      r_coords <= {8{PARKED}};
      r_count  <= '0;
      r_missed <= 1'b0;
    end else begin
      r_lfsr   <= {w_fb, r_lfsr[15:1]};
      r_cnt    <= w_cnt_nxt;
      r_due    <= w_due_nxt;
      r_active <= w_act_nxt;
      r_coords <= w_crd_nxt;
      r_count  <= w_count_nxt;
      r_missed <= w_missed_nxt;
    end
  end
endmodule
